program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 161 ++++++++++++++++
 tb/tb_program_loader.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Byte-stream program loader: length header, LE payload words, optional checksum.
// LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and the CHECK state.
module program_loader #(
  parameter int PC_WIDTH  = 12,
  parameter int MAX_WORDS = 2**PC_WIDTH/4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic                pmem_w_en,
  output logic [PC_WIDTH-1:0] pmem_addr,
  output logic [31:0]         pmem_w_data,
  output logic                cpu_rst,
  output logic                done,
  output logic                error
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    LEN_LO, LEN_HI, PAYLOAD, CHECK, DONE, ERROR
  } state_t;
  logic [7:0] csum_q, csum_d;
`else
  typedef enum logic [2:0] {
    LEN_LO, LEN_HI, PAYLOAD, DONE, ERROR
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [15:0]         word_cnt_q, word_cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [23:0]         word_q, word_d;
  logic                w_en_q, w_en_d;
  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic                rdy_q, rdy_d;

  logic        accept;
  logic        last_wr;
  logic [15:0] len_full;

  assign accept   = rx_valid & rdy_q;
  assign len_full = {rx_data, len_q[7:0]};
  assign last_wr  = w_en_q &
                    ({1'b0, word_cnt_q} + 17'd1 == {1'b0, len_q});

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    idx_d      = idx_q;
    word_d     = word_q;
    w_en_d     = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    if (w_en_q) word_cnt_d = word_cnt_q + 16'd1;

    unique case (state_q)
      LEN_LO: if (accept) begin
        len_d[7:0] = rx_data;
        state_d    = LEN_HI;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q ^ rx_data;
`endif
      end
      LEN_HI: if (accept) begin
        len_d = len_full;
`ifdef LOADER_CHECKSUM_EN
        csum_d = csum_q ^ rx_data;
`endif
        if ({16'd0, len_full} > MAX_WORDS) state_d = ERROR;
`ifdef LOADER_CHECKSUM_EN
        else if (len_full == 16'd0) state_d = CHECK;
`else
        else if (len_full == 16'd0) state_d = DONE;
`endif
        else state_d = PAYLOAD;
      end
      PAYLOAD: begin
        if (last_wr) begin
`ifdef LOADER_CHECKSUM_EN
          // checksum byte may already arrive during the final write cycle
          if (accept)
            state_d = (rx_data == csum_q) ? DONE : ERROR;
          else
            state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else if (accept) begin
          idx_d = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          unique case (idx_q)
            2'd0: word_d[7:0]   = rx_data;
            2'd1: word_d[15:8]  = rx_data;
            2'd2: word_d[23:16] = rx_data;
            default: begin
              w_en_d = 1'b1;
              data_d = {rx_data, word_q};
              addr_d = PC_WIDTH'({word_cnt_q, 2'b00});
            end
          endcase
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: if (accept)
        state_d = (rx_data == csum_q) ? DONE : ERROR;
`endif
      default: ;
    endcase

    rdy_d = (state_d != DONE) && (state_d != ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LEN_LO;
      len_q      <= '0;
      word_cnt_q <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      w_en_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rdy_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      w_en_q     <= w_en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rdy_q      <= rdy_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign rx_ready    = rdy_q;
  assign pmem_w_en   = w_en_q;
  assign pmem_addr   = addr_q;
  assign pmem_w_data = data_q;
  assign cpu_rst     = (state_q != DONE);
  assign done        = (state_q == DONE);
  assign error       = (state_q == ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: vector table, timing sequences, random streams.
// Checksum cases follow LOADER_CHECKSUM_EN when defined.
module tb_program_loader;
  localparam int PCW  = 12;
  localparam int MAXW = 1024;

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic           rx_ready;
  logic           pmem_w_en;
  logic [PCW-1:0] pmem_addr;
  logic [31:0]    pmem_w_data;
  logic           cpu_rst;
  logic           done;
  logic           error;

  program_loader #(.PC_WIDTH(PCW)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .pmem_w_en(pmem_w_en), .pmem_addr(pmem_addr),
    .pmem_w_data(pmem_w_data),
    .cpu_rst(cpu_rst), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [PCW-1:0] mon_addr[$];
  logic [31:0]    mon_data[$];
  logic           prev_wen = 1'b0;
  int             dbl_pulse = 0;

  always @(negedge clk) begin
    if (pmem_w_en) begin
      mon_addr.push_back(pmem_addr);
      mon_data.push_back(pmem_w_data);
      if (prev_wen) dbl_pulse++;
    end
    prev_wen = pmem_w_en;
  end

  logic [PCW-1:0] exp_addr[$];
  logic [31:0]    exp_data[$];
  logic           exp_done, exp_err;
  int             exp_nsend;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    tick();
    mon_addr.delete();
    mon_data.delete();
    dbl_pulse = 0;
  endtask

  task automatic send_bytes(input logic [7:0] s[$], input int gap);
    int t;
    foreach (s[i]) begin
      repeat ($urandom_range(0, gap)) begin
        rx_valid = 1'b0;
        rx_data = 8'($urandom);
        tick();
      end
      rx_valid = 1'b1;
      rx_data = s[i];
      t = 0;
      while (!rx_ready && t < 50) begin
        tick();
        t++;
      end
      if (t == 50) chk("accept_timeout", 0, 1);
      tick();
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_end();
    int t = 0;
    while (!(done || error) && t < 40) begin
      tick();
      t++;
    end
    chk("end_reached", 32'(done || error), 1);
  endtask

  function automatic logic [7:0] xor_all(input logic [7:0] s[$]);
    logic [7:0] x = 8'h00;
    foreach (s[i]) x ^= s[i];
    return x;
  endfunction

  // Reference: parse the stream as a sequence of fields
  function automatic void model(input logic [7:0] s[$]);
    int len;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    len = int'(s[0]) + 256 * int'(s[1]);
    x = s[0] ^ s[1];
    if (len > MAXW) begin
      exp_done = 1'b0;
      exp_err = 1'b1;
      exp_nsend = 2;
      return;
    end
    for (int w = 0; w < len; w++) begin
      logic [31:0] d = 0;
      for (int k = 0; k < 4; k++) begin
        d = d + (32'(s[2 + 4*w + k]) << (8*k));
        x ^= s[2 + 4*w + k];
      end
      exp_addr.push_back(PCW'((w * 4) % (1 << PCW)));
      exp_data.push_back(d);
    end
    exp_nsend = 2 + 4 * len;
`ifdef LOADER_CHECKSUM_EN
    exp_err = (s[exp_nsend] != x);
    exp_nsend++;
`else
    exp_err = 1'b0;
`endif
    exp_done = !exp_err;
  endfunction

  task automatic run_model(input string tag, input logic [7:0] s[$],
                           input int gap);
    logic [7:0] sub[$];
    int nwr;
    do_reset();
    model(s);
    sub = s[0:exp_nsend-1];
    send_bytes(sub, gap);
    wait_end();
    tick();
    chk({tag, "_nwr"}, mon_addr.size(), exp_addr.size());
    if (mon_addr.size() == exp_addr.size()) begin
      foreach (exp_addr[i]) begin
        chk({tag, "_addr"}, 32'(mon_addr[i]), 32'(exp_addr[i]));
        chk({tag, "_data"}, mon_data[i], exp_data[i]);
      end
    end
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_err"}, 32'(error), 32'(exp_err));
    chk({tag, "_cpurst"}, 32'(cpu_rst), 32'(!exp_done));
    chk({tag, "_rdy"}, 32'(rx_ready), 0);
    nwr = mon_addr.size();
    repeat (8) begin
      rx_valid = 1'($urandom);
      rx_data = 8'($urandom);
      tick();
    end
    rx_valid = 1'b0;
    chk({tag, "_sticky_nwr"}, mon_addr.size(), nwr);
    chk({tag, "_sticky_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_pulse"}, dbl_pulse, 0);
  endtask

  typedef struct {
    logic [95:0] bytes;
    int          n;
    logic        e_done;
    logic        e_err;
    int          e_nwr;
    logic [31:0] e_addr;
    logic [31:0] e_data;
  } vec_t;

  initial begin
    vec_t        tbl[5];
    logic [7:0]  s[$];
    logic [95:0] bv;

    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    tick();
    tick();
    chk("rst_rdy", 32'(rx_ready), 0);
    chk("rst_wen", 32'(pmem_w_en), 0);
    chk("rst_addr", 32'(pmem_addr), 0);
    chk("rst_data", pmem_w_data, 0);
    chk("rst_cpurst", 32'(cpu_rst), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(error), 0);
    rst = 1'b0;
    tick();
    chk("rst_rel_rdy", 32'(rx_ready), 1);

    tbl[0] = '{96'h0200_1300_0000_9300_1000_0000, 10,
               1'b1, 1'b0, 2, 32'h4, 32'h0010_0093};
    tbl[1] = '{96'h0104_0000_0000_0000_0000_0000, 2,
               1'b0, 1'b1, 0, 32'h0, 32'h0};
    tbl[2] = '{96'h0000_0000_0000_0000_0000_0000, 2,
               1'b1, 1'b0, 0, 32'h0, 32'h0};
    tbl[3] = '{96'h0100_AABB_CCDD_0000_0000_0000, 6,
               1'b1, 1'b0, 1, 32'h0, 32'hDDCC_BBAA};
    tbl[4] = '{96'h00FF_0000_0000_0000_0000_0000, 2,
               1'b0, 1'b1, 0, 32'h0, 32'h0};
    for (int v = 0; v < 5; v++) begin
      s.delete();
      bv = tbl[v].bytes;
      for (int i = 0; i < tbl[v].n; i++) s.push_back(bv[95-8*i -: 8]);
`ifdef LOADER_CHECKSUM_EN
      if (!tbl[v].e_err) s.push_back(xor_all(s));
`endif
      do_reset();
      send_bytes(s, 1);
      wait_end();
      tick();
      chk($sformatf("vec%0d_nwr", v), mon_addr.size(), tbl[v].e_nwr);
      if (tbl[v].e_nwr > 0 && mon_addr.size() > 0) begin
        chk($sformatf("vec%0d_addr", v), 32'(mon_addr[$]), tbl[v].e_addr);
        chk($sformatf("vec%0d_data", v), mon_data[$], tbl[v].e_data);
      end
      chk($sformatf("vec%0d_done", v), 32'(done), 32'(tbl[v].e_done));
      chk($sformatf("vec%0d_err", v), 32'(error), 32'(tbl[v].e_err));
    end

`ifndef LOADER_CHECKSUM_EN
    // write pulse one cycle after last byte, done the cycle after
    do_reset();
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
          8'h93, 8'h00, 8'h10, 8'h00};
    send_bytes(s, 0);
    chk("t35_wen", 32'(pmem_w_en), 1);
    chk("t35_addr", 32'(pmem_addr), 32'h4);
    chk("t35_data", pmem_w_data, 32'h0010_0093);
    chk("t35_done_early", 32'(done), 0);
    tick();
    chk("t35_done", 32'(done), 1);
    chk("t35_cpurst", 32'(cpu_rst), 0);
    chk("t35_wen_off", 32'(pmem_w_en), 0);

    do_reset();
    s = '{8'h00, 8'h00};
    send_bytes(s, 0);
    chk("t40_done", 32'(done), 1);
    chk("t40_nwr", mon_addr.size(), 0);
`endif

    do_reset();
    s = '{8'h01, 8'h04};
    send_bytes(s, 0);
    chk("t37_err", 32'(error), 1);
    chk("t37_rdy", 32'(rx_ready), 0);
    chk("t37_cpurst", 32'(cpu_rst), 1);
    repeat (4) tick();
    chk("t37_nwr", mon_addr.size(), 0);

    // reset in the middle of a word
    do_reset();
    s = '{8'h01, 8'h00, 8'h11, 8'h22};
    send_bytes(s, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    repeat (3) tick();
    chk("t39_nowr", mon_addr.size(), 0);
    s = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef LOADER_CHECKSUM_EN
    s.push_back(xor_all(s));
`endif
    send_bytes(s, 0);
    wait_end();
    chk("t39_nwr", mon_addr.size(), 1);
    if (mon_addr.size() == 1) begin
      chk("t39_addr", 32'(mon_addr[0]), 0);
      chk("t39_data", mon_data[0], 32'hDDCC_BBAA);
    end
    chk("t39_done", 32'(done), 1);

    // reset landing on the write cycle
    do_reset();
    s = '{8'h01, 8'h00, 8'h55, 8'h66, 8'h77, 8'h88};
    send_bytes(s, 0);
    chk("rw_wen", 32'(pmem_w_en), 1);
    rst = 1'b1;
    tick();
    chk("rw_wen_clr", 32'(pmem_w_en), 0);
    chk("rw_data_clr", pmem_w_data, 0);
    chk("rw_rdy", 32'(rx_ready), 0);
    tick();
    chk("rw_rdy_held", 32'(rx_ready), 0);
    rst = 1'b0;
    tick();
    chk("rw_rdy_rel", 32'(rx_ready), 1);

    // full-size program at full rate
    s.delete();
    s.push_back(8'h00);
    s.push_back(8'h04);
    for (int i = 0; i < 4 * MAXW; i++) s.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
    s.push_back(xor_all(s));
`endif
    run_model("max", s, 0);
    chk("max_pulses", mon_addr.size(), MAXW);
    if (mon_addr.size() > 0)
      chk("max_last_addr", 32'(mon_addr[$]), 32'hFFC);

    for (int r = 0; r < 30; r++) begin
      int len;
      s.delete();
      len = $urandom_range(0, 6);
      if ($urandom_range(0, 7) == 0)
        len = ($urandom_range(0, 1) == 1) ? 16'hFFFF
                                           : MAXW + 1 + $urandom_range(0, 99);
      s.push_back(8'(len));
      s.push_back(8'(len >> 8));
      if (len <= MAXW) begin
        for (int i = 0; i < 4 * len; i++) s.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
        s.push_back(xor_all(s) ^ 8'($urandom_range(0, 1)));
`endif
      end
      run_model($sformatf("rnd%0d", r), s, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
